dawson64_op_seq: RTL and testbench

- Upstream feeder and result collector for dawson64_if.
- Buffers (a, b) operand pairs from a valid/ready producer in an operand FIFO and issues them one at a time to dawson64_if's user side (a, b, ready_in).
- Captures each one-cycle out/ready_out result into a result FIFO for a valid/ready consumer.
- Issues only when result space is guaranteed, so a result is never lost; a watchdog stops operation if the unit hangs.

---
 rtl/dawson64_pkg.sv | 18 +
 rtl/dawson64_sync_fifo.sv | 53 +++++
 rtl/dawson64_op_seq.sv | 125 ++++++++++++
 tb/tb_dawson64_op_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dawson64_pkg.sv
// rtl/dawson64_pkg.sv - shared types for the dawson64 operand sequencer
package dawson64_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HALT
  } seq_state_t;

  typedef struct packed {
    word_t a;
    word_t b;
  } op_pair_t;

endpackage

// File: rtl/dawson64_sync_fifo.sv
// rtl/dawson64_sync_fifo.sv - single-clock FIFO with occupancy count
module dawson64_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dawson64_op_seq.sv
// rtl/dawson64_op_seq.sv - operand feeder and result collector for dawson64_if
module dawson64_op_seq
  import dawson64_pkg::*;
#(
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [63:0] if_a,
  output logic [63:0] if_b,
  output logic        if_ready_in,
  input  logic [63:0] if_out,
  input  logic        if_ready_out,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_spurious
);

  localparam int OAW = $clog2(OP_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam logic [RAW:0] RES_FULL_CNT = (RAW+1)'(RES_DEPTH);
  localparam logic [31:0]  WD_LAST      = TIMEOUT - 1;

  seq_state_t    state, state_next;
  op_pair_t      op_in, op_head;
  logic          op_full, op_empty;
  logic [OAW:0]  op_count;
  logic          res_full, res_empty;
  logic [RAW:0]  res_count;
  word_t         res_head;
  logic          push_op, pop_res;
  logic          issue, capture, expire;
  logic [31:0]   wd;

  assign op_in     = '{a: op_a, b: op_b};
  assign op_ready  = reset_n && !op_full && (state != HALT);
  assign push_op   = op_valid && op_ready;
  assign res_valid = !res_empty;
  assign pop_res   = res_valid && res_ready;
  assign res_data  = res_empty ? '0 : res_head;
  assign if_ready_in = (state == ISSUE);
  assign busy      = (state != IDLE) || (op_count != '0);

  dawson64_sync_fifo #(.WIDTH(128), .DEPTH(OP_DEPTH)) u_op_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_op),
    .din     (op_in),
    .pop     (issue),
    .dout    (op_head),
    .full    (op_full),
    .empty   (op_empty),
    .count   (op_count)
  );

  dawson64_sync_fifo #(.WIDTH(64), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (capture),
    .din     (if_out),
    .pop     (pop_res),
    .dout    (res_head),
    .full    (res_full),
    .empty   (res_empty),
    .count   (res_count)
  );

  // Issue only from IDLE with a free result slot, so the one in-flight result always fits.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (!op_empty && (res_count < RES_FULL_CNT)) begin
          issue      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (if_ready_out && !res_full) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT != 0) && (wd == WD_LAST)) begin
          expire     = 1'b1;
          state_next = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      if_a         <= '0;
      if_b         <= '0;
      wd           <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) begin
        if_a <= op_head.a;
        if_b <= op_head.b;
      end
      wd <= ((state == WAIT) && (state_next == WAIT)) ? wd + 32'd1 : '0;
      if (expire) err_timeout <= 1'b1;
      if (if_ready_out && (state != WAIT)) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dawson64_op_seq.sv
// tb/tb_dawson64_op_seq.sv - self-checking bench for dawson64_op_seq
module tb_dawson64_op_seq;

  logic        clock;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [63:0] if_a;
  logic [63:0] if_b;
  logic        if_ready_in;
  logic [63:0] if_out;
  logic        if_ready_out;
  logic        busy;
  logic        err_timeout;
  logic        err_spurious;

  dawson64_op_seq #(.OP_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .if_a         (if_a),
    .if_b         (if_b),
    .if_ready_in  (if_ready_in),
    .if_out       (if_out),
    .if_ready_out (if_ready_out),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference: every accepted pair must come back as a+b, in acceptance order.
  logic [63:0] exp_q[$];

  // Stand-in for dawson64_if: answers a+b a chosen number of cycles after ready_in.
  bit          pend, spur_req, answer_en, rand_lat, prev_rin;
  int          cd, lat, issue_cnt, stab_err, rin_err;
  logic [63:0] pa, pb, spur_data;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] sum;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_unexpected actual=%0h required=none", res_data);
        end else begin
          chk("res_order", res_data, exp_q.pop_front());
        end
      end
      if (op_valid && op_ready) exp_q.push_back(op_a + op_b);
    end
  endtask

  task automatic responder();
    if (!reset_n) begin
      pend = 0;
      prev_rin = 0;
      if_ready_out = 1'b0;
      return;
    end
    if_ready_out = 1'b0;
    if (pend) begin
      if (if_a !== pa || if_b !== pb) stab_err++;
      if (cd == 0) begin
        if_ready_out = 1'b1;
        if_out = pa + pb;
        pend = 0;
      end else begin
        cd--;
      end
    end else if (spur_req) begin
      if_ready_out = 1'b1;
      if_out = spur_data;
      spur_req = 0;
    end
    if (if_ready_in) begin
      issue_cnt++;
      if (prev_rin || pend) rin_err++;
      if (answer_en) begin
        pend = 1;
        cd = (rand_lat ? int'($urandom_range(6, 1)) : lat) - 1;
        pa = if_a;
        pb = if_b;
      end
    end
    prev_rin = if_ready_in;
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    responder();
  endtask

  task automatic push_pair(input logic [63:0] a, input logic [63:0] b);
    logic ok;
    ok = 1'b0;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int i = 0; i < 100; i++) begin
      ok = op_ready;
      tick();
      if (ok) break;
    end
    op_valid = 1'b0;
    chk("push_accepted", ok, 1);
  endtask

  task automatic wait_issue(input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (if_ready_in) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("issue_seen", found, 1);
  endtask

  task automatic wait_res(input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (res_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("res_seen", found, 1);
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic drain(input int bound);
    logic done;
    done = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !busy && !res_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    res_ready = 1'b0;
    chk("drain_done", done, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic found;
    reset_n = 1'b0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    if_out = '0;
    if_ready_out = 1'b0;
    answer_en = 1;
    rand_lat = 0;
    lat = 2;
    spur_req = 0;
    spur_data = '0;
    issue_cnt = 0;
    stab_err = 0;
    rin_err = 0;

    vecs[0] = '{64'd1, 64'd2, 1, 64'd3};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3, 64'd0};
    vecs[2] = '{64'd10, 64'd0, 2, 64'd10};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6, 64'd0};
    vecs[4] = '{64'd123456789, 64'd987654321, 4, 64'd1111111110};

    tick();
    tick();
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_if_ready_in", if_ready_in, 0);
    chk("rst_if_a", if_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_spurious", err_spurious, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_op_ready", op_ready, 1);

    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      push_pair(vecs[i].a, vecs[i].b);
      chk("vec_no_early_issue", if_ready_in, 0);
      tick();
      chk("vec_issue", if_ready_in, 1);
      chk("vec_if_a", if_a, vecs[i].a);
      chk("vec_if_b", if_b, vecs[i].b);
      tick();
      chk("vec_issue_one_cycle", if_ready_in, 0);
      wait_res(20);
      chk("vec_res_data", res_data, vecs[i].sum);
      pop_one();
      chk("vec_res_empty", res_valid, 0);
      chk("vec_res_data_zero", res_data, 0);
      chk("vec_idle", busy, 0);
    end

    lat = 6;
    base = issue_cnt;
    for (int i = 0; i < 5; i++) push_pair(64'(i + 5), 64'd5);
    chk("b2b_op_full", op_ready, 0);
    drain(200);
    chk("b2b_issues", issue_cnt - base, 5);

    lat = 1;
    base = issue_cnt;
    for (int i = 0; i < 6; i++) push_pair(64'(100 + i), 64'(i));
    repeat (30) tick();
    chk("full_issues", issue_cnt - base, 4);
    chk("full_res_valid", res_valid, 1);
    chk("full_busy", busy, 1);
    chk("full_op_ready", op_ready, 1);
    pop_one();
    found = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (if_ready_in) found = 1'b1;
    end
    chk("full_issue_after_pop", found, 1);
    drain(200);
    chk("full_total_issues", issue_cnt - base, 6);

    chk("spur_before", err_spurious, 0);
    spur_data = 64'd99;
    spur_req = 1;
    tick();
    tick();
    chk("spur_flag", err_spurious, 1);
    chk("spur_res_valid", res_valid, 0);
    chk("spur_busy", busy, 0);

    rand_lat = 1;
    for (int c = 0; c < 400; c++) begin
      op_valid = 1'($urandom_range(1, 0));
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      res_ready = 1'($urandom_range(1, 0));
      tick();
    end
    op_valid = 1'b0;
    drain(400);
    rand_lat = 0;

    lat = 2;
    push_pair(64'd20, 64'd22);
    wait_res(20);
    chk("to_queued_res", res_data, 64'd42);
    answer_en = 0;
    push_pair(64'd1, 64'd1);
    wait_issue(20);
    base = issue_cnt;
    tick();
    repeat (7) tick();
    chk("to_not_yet", err_timeout, 0);
    tick();
    chk("to_flag", err_timeout, 1);
    chk("to_op_ready", op_ready, 0);
    chk("to_busy", busy, 1);
    op_valid = 1'b1;
    op_a = 64'd3;
    op_b = 64'd4;
    repeat (10) tick();
    op_valid = 1'b0;
    chk("to_no_issue", issue_cnt - base, 0);
    chk("to_rin_low", if_ready_in, 0);
    chk("to_res_poppable", res_valid, 1);
    pop_one();
    chk("to_res_empty", res_valid, 0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("halt_cleared", err_timeout, 0);
    push_pair(64'd1, 64'd2);
    push_pair(64'd3, 64'd4);
    push_pair(64'd5, 64'd6);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_op_ready", op_ready, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_if_a", if_a, 0);
    chk("mid_rst_if_b", if_b, 0);
    chk("mid_rst_if_ready_in", if_ready_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_spurious", err_spurious, 0);
    reset_n = 1'b1;
    answer_en = 1;
    lat = 2;
    tick();
    chk("mid_post_op_ready", op_ready, 1);
    chk("mid_post_busy", busy, 0);
    push_pair(64'd5, 64'd6);
    wait_res(20);
    chk("mid_post_res", res_data, 64'd11);
    pop_one();
    chk("mid_post_empty", res_valid, 0);

    chk("if_ab_stable_in_wait", 64'(stab_err), 0);
    chk("ready_in_single_pulse", 64'(rin_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
